// File: rtl/core_dbg_pkg.sv
// Shared debug-control definitions: run-mode encodings and the run controller FSM state type.
package core_dbg_pkg;

  localparam logic [1:0] MODE_HALT   = 2'b00;
  localparam logic [1:0] MODE_STEP   = 2'b01;
  localparam logic [1:0] MODE_RUN    = 2'b10;
  localparam logic [1:0] MODE_RUN_BP = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_BRK  = 2'b10
  } state_t;

endpackage

// File: rtl/core_run_ctrl_if.sv
// Debug/run-control bus between a host (master) and the core run controller (slave).
interface core_run_ctrl_if
  import core_dbg_pkg::*;
#(
  parameter int DIV_W  = 16,
  parameter int NUM_BP = 4,
  parameter int ADDR_W = 32
);
  // No valid/ready pairs: every control input is a level sampled on each rising clk;
  // cpu_ce is a single-cycle strobe and the remaining outputs are registered levels.
  logic                     step;
  logic [1:0]               mode;
  logic [DIV_W-1:0]         div_sel;
  logic [ADDR_W-1:0]        pc_in;
  logic [NUM_BP*ADDR_W-1:0] bp_addr;
  logic [NUM_BP-1:0]        bp_valid;
  logic                     cnt_clr;
  logic                     cpu_ce;
  logic                     halted;
  logic [NUM_BP-1:0]        bp_hit;
  logic [31:0]              cycle_count;
  state_t                   dbg_state;

  modport master (
    output step, mode, div_sel, pc_in, bp_addr, bp_valid, cnt_clr,
    input  cpu_ce, halted, bp_hit, cycle_count, dbg_state
  );

  modport slave (
    input  step, mode, div_sel, pc_in, bp_addr, bp_valid, cnt_clr,
    output cpu_ce, halted, bp_hit, cycle_count, dbg_state
  );
endinterface

// File: rtl/core_run_ctrl_step_sync.sv
// Two-flop synchronizer for the asynchronous step button plus a registered rising-edge strobe.
module step_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_step,
  output logic o_step_evt
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;
  logic r_evt;

  // The edge strobe is registered so a press reaches cpu_ce on the third edge after first sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_evt   <= 1'b0;
    end else begin
      r_sync1 <= i_step;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_evt   <= r_sync2 & ~r_sync3;
    end
  end

  assign o_step_evt = r_evt;

endmodule

// File: rtl/core_run_ctrl.sv
// Core run controller: halt / single-step / free-run / run-to-breakpoint clock-enable generation.
module core_run_ctrl
  import core_dbg_pkg::*;
#(
  parameter int DIV_W  = 16,
  parameter int NUM_BP = 4,
  parameter int ADDR_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  core_run_ctrl_if.slave   bus
);

  localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DIV_W-1:0]   r_div;
  logic [DIV_W-1:0]   w_div_nxt;
  logic [1:0]         r_mode_prev;
  logic               r_cpu_ce;
  logic               w_ce_nxt;
  logic               r_halted;
  logic [NUM_BP-1:0]  r_bp_hit;
  logic [NUM_BP-1:0]  w_hit_nxt;
  logic [NUM_BP-1:0]  w_match;
  logic [31:0]        r_cycle_count;
  logic               w_step_evt;
  logic               w_mode_chg;
  logic               w_run_mode;

  step_sync u_step_sync (
    .clk        (clk),
    .rst        (rst),
    .i_step     (bus.step),
    .o_step_evt (w_step_evt)
  );

  assign w_mode_chg = (bus.mode != r_mode_prev);
  assign w_run_mode = bus.mode[1];

  always_comb begin
    w_match = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      w_match[i] = bus.bp_valid[i] && (bus.pc_in == bus.bp_addr[i*ADDR_W +: ADDR_W]);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ce_nxt    = 1'b0;
    w_hit_nxt   = r_bp_hit;
    w_div_nxt   = '0;
    case (r_state)
      ST_IDLE: begin
        if (bus.mode == MODE_STEP) begin
          w_ce_nxt = w_step_evt;
        end else if (w_run_mode) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.mode == MODE_HALT) begin
          w_state_nxt = ST_IDLE;
        end else if (bus.mode == MODE_STEP) begin
          w_state_nxt = ST_IDLE;
          w_hit_nxt   = '0;
        end else if (r_div == bus.div_sel) begin
          // A breakpoint is only consulted at the cycle that would otherwise pulse.
          if ((bus.mode == MODE_RUN_BP) && (|w_match)) begin
            w_state_nxt = ST_BRK;
            w_hit_nxt   = w_match;
          end else begin
            w_ce_nxt = 1'b1;
          end
        end else begin
          w_div_nxt = r_div + DIV_ONE;
        end
      end
      ST_BRK: begin
        if (bus.mode == MODE_HALT) begin
          w_state_nxt = ST_IDLE;
        end else if (bus.mode == MODE_STEP) begin
          w_state_nxt = ST_IDLE;
          w_hit_nxt   = '0;
        end else if (w_step_evt) begin
          w_ce_nxt    = 1'b1;
          w_hit_nxt   = '0;
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (w_mode_chg) begin
      w_div_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_div       <= '0;
      r_mode_prev <= MODE_HALT;
      r_cpu_ce    <= 1'b0;
      r_halted    <= 1'b1;
      r_bp_hit    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_div       <= w_div_nxt;
      r_mode_prev <= bus.mode;
      r_cpu_ce    <= w_ce_nxt;
      r_halted    <= (w_state_nxt != ST_RUN);
      r_bp_hit    <= w_hit_nxt;
    end
  end

  // The counter advances on the same edge that raises cpu_ce; a clear wins over that increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_count <= '0;
    end else if (bus.cnt_clr) begin
      r_cycle_count <= '0;
    end else if (w_ce_nxt) begin
      r_cycle_count <= r_cycle_count + 32'd1;
    end
  end

  assign bus.cpu_ce      = r_cpu_ce;
  assign bus.halted      = r_halted;
  assign bus.bp_hit      = r_bp_hit;
  assign bus.cycle_count = r_cycle_count;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl: every cpu_ce pulse is scored against an expected cycle_count queue.
module tb_core_run_ctrl;
  import core_dbg_pkg::*;

  localparam int DIV_W  = 16;
  localparam int NUM_BP = 4;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst;

  core_run_ctrl_if #(.DIV_W(DIV_W), .NUM_BP(NUM_BP), .ADDR_W(ADDR_W)) bus_if ();

  core_run_ctrl #(.DIV_W(DIV_W), .NUM_BP(NUM_BP), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_cnt = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pulse();
    m_cnt = m_cnt + 32'd1;
    exp_q.push_back(m_cnt);
  endtask

  always @(negedge clk) begin
    if (bus_if.cpu_ce === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_pulse", {31'b0, bus_if.cpu_ce}, 32'd0);
      else                   chk("pulse_count", bus_if.cycle_count, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ce(input string tag, input int max_cyc, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while ((bus_if.cpu_ce !== 1'b1) && (cyc < max_cyc));
    chk({tag, "_seen"}, {31'b0, bus_if.cpu_ce}, 32'd1);
  endtask

  task automatic step_press(input string tag, input int hold, input bit exp_pulse);
    int pulses;
    int first;
    pulses = 0;
    first  = -1;
    bus_if.step = 1'b1;
    for (int c = 0; c < hold; c++) begin
      tick();
      if (bus_if.cpu_ce === 1'b1) begin
        pulses++;
        if (first < 0) first = c;
      end
    end
    bus_if.step = 1'b0;
    tick(4);
    chk({tag, "_pulses"}, pulses, exp_pulse ? 32'd1 : 32'd0);
    if (exp_pulse) chk({tag, "_delay"}, first, 32'd3);
  endtask

  task automatic chk_state(input string tag, input state_t exp);
    chk(tag, {30'b0, bus_if.dbg_state}, {30'b0, exp});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    rst             = 1'b1;
    bus_if.step     = 1'b0;
    bus_if.mode     = MODE_HALT;
    bus_if.div_sel  = '0;
    bus_if.pc_in    = '0;
    bus_if.bp_addr  = '0;
    bus_if.bp_valid = '0;
    bus_if.cnt_clr  = 1'b0;
    tick(3);
    rst = 1'b0;
    tick();
    chk("rst_cpu_ce", {31'b0, bus_if.cpu_ce}, 32'd0);
    chk("rst_halted", {31'b0, bus_if.halted}, 32'd1);
    chk("rst_bp_hit", {28'b0, bus_if.bp_hit}, 32'd0);
    chk("rst_count", bus_if.cycle_count, 32'd0);
    chk_state("rst_state", ST_IDLE);

    // Free run, div_sel=3: pulse every 4th cycle, 10 pulses.
    bus_if.div_sel = 16'd3;
    bus_if.mode    = MODE_RUN;
    for (int k = 0; k < 10; k++) push_pulse();
    wait_ce("run3_first", 20, cyc);
    chk("run3_first_lat", cyc, 32'd5);
    chk("run3_halted", {31'b0, bus_if.halted}, 32'd0);
    for (int k = 1; k < 10; k++) begin
      wait_ce("run3", 20, cyc);
      chk("run3_gap", cyc, 32'd4);
    end
    bus_if.mode = MODE_HALT;
    chk("run3_count", bus_if.cycle_count, 32'd10);
    tick(2);
    chk_state("halt_state", ST_IDLE);
    chk("halt_halted", {31'b0, bus_if.halted}, 32'd1);

    // Step button ignored while halted; in STEP mode each press gives one pulse.
    step_press("halt_step", 8, 1'b0);
    bus_if.mode = MODE_STEP;
    push_pulse();
    step_press("step1", 20, 1'b1);
    push_pulse();
    step_press("step2", 8, 1'b1);
    chk("step_count", bus_if.cycle_count, 32'd12);

    // Run to breakpoint on entry 2, then resume with a step.
    bus_if.bp_addr[2*ADDR_W +: ADDR_W] = 32'h40;
    bus_if.bp_valid = 4'b0100;
    bus_if.pc_in    = 32'h40;
    bus_if.div_sel  = 16'd3;
    bus_if.mode     = MODE_RUN_BP;
    tick(10);
    chk("bp_hit_single", {28'b0, bus_if.bp_hit}, 32'h4);
    chk("bp_halted", {31'b0, bus_if.halted}, 32'd1);
    chk_state("bp_state", ST_BRK);
    bus_if.pc_in   = 32'h44;
    bus_if.div_sel = 16'd100;
    push_pulse();
    step_press("brk_step", 6, 1'b1);
    chk("brk_resume_hit", {28'b0, bus_if.bp_hit}, 32'd0);
    chk("brk_resume_halted", {31'b0, bus_if.halted}, 32'd0);
    chk_state("brk_resume_state", ST_RUN);
    bus_if.mode = MODE_HALT;
    tick(2);

    // Two valid matching entries; matching but disabled entries must not be reported.
    for (int i = 0; i < NUM_BP; i++) bus_if.bp_addr[i*ADDR_W +: ADDR_W] = 32'h80;
    bus_if.bp_valid = 4'b0011;
    bus_if.pc_in    = 32'h80;
    bus_if.div_sel  = 16'd0;
    bus_if.mode     = MODE_RUN_BP;
    tick(4);
    chk("bp_hit_dual", {28'b0, bus_if.bp_hit}, 32'h3);
    chk_state("bp_dual_state", ST_BRK);
    bus_if.mode = MODE_STEP;
    tick(2);
    chk("brk_to_step_hit", {28'b0, bus_if.bp_hit}, 32'd0);
    chk_state("brk_to_step_state", ST_IDLE);

    // div_sel=0: pulse every cycle, then a one-cycle reset on a pulse cycle.
    bus_if.bp_valid = '0;
    bus_if.pc_in    = '0;
    bus_if.mode     = MODE_RUN;
    for (int k = 0; k < 5; k++) push_pulse();
    wait_ce("run0_first", 10, cyc);
    chk("run0_first_lat", cyc, 32'd2);
    for (int k = 1; k < 5; k++) begin
      wait_ce("run0", 10, cyc);
      chk("run0_gap", cyc, 32'd1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_cnt = '0;
    chk("mid_rst_cpu_ce", {31'b0, bus_if.cpu_ce}, 32'd0);
    chk("mid_rst_halted", {31'b0, bus_if.halted}, 32'd1);
    chk("mid_rst_count", bus_if.cycle_count, 32'd0);
    chk_state("mid_rst_state", ST_IDLE);
    tick();
    chk_state("post_rst_state", ST_RUN);
    chk("post_rst_halted", {31'b0, bus_if.halted}, 32'd0);
    for (int k = 0; k < 3; k++) push_pulse();
    for (int k = 0; k < 3; k++) begin
      wait_ce("post_rst", 10, cyc);
      chk("post_rst_gap", cyc, 32'd1);
    end
    bus_if.mode = MODE_HALT;
    tick(2);

    // div_sel changes mid-run: a larger counter must wrap around rather than pulse early.
    bus_if.div_sel = 16'd5;
    bus_if.mode    = MODE_RUN;
    push_pulse();
    wait_ce("div5", 20, cyc);
    chk("div5_lat", cyc, 32'd7);
    bus_if.div_sel = 16'd2;
    push_pulse();
    wait_ce("div2", 10, cyc);
    chk("div2_gap", cyc, 32'd3);
    bus_if.div_sel = 16'd7;
    tick(4);
    bus_if.div_sel = 16'd1;
    tick(40);
    chk("div_shrink_count", bus_if.cycle_count, m_cnt);
    bus_if.mode = MODE_HALT;
    tick(2);

    // Counter wrap on a step pulse.
    force dut.r_cycle_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_cycle_count;
    chk("preload_count", bus_if.cycle_count, 32'hFFFF_FFFF);
    bus_if.mode = MODE_STEP;
    m_cnt = 32'hFFFF_FFFF;
    push_pulse();
    step_press("wrap_step", 8, 1'b1);
    chk("wrap_count", bus_if.cycle_count, 32'd0);

    // Clear coinciding with a run pulse wins over the increment.
    force dut.r_cycle_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_cycle_count;
    bus_if.div_sel = 16'd3;
    bus_if.mode    = MODE_RUN;
    m_cnt = '0;
    exp_q.push_back(32'd0);
    tick(4);
    chk("clr_pre_count", bus_if.cycle_count, 32'hFFFF_FFFF);
    bus_if.cnt_clr = 1'b1;
    tick();
    bus_if.cnt_clr = 1'b0;
    chk("clr_pulse_ce", {31'b0, bus_if.cpu_ce}, 32'd1);
    chk("clr_count", bus_if.cycle_count, 32'd0);
    bus_if.mode = MODE_HALT;
    tick(5);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
